// File: rtl/btb_valid_bank.sv
// Valid-bit bank for the BTB: per-way valid bits, per-set round-robin victim pointer,
// lookup/write/allocate ports and a flush sweep. Define BTB_VALID_FLASH_CLEAR_EN for a one-edge flush.
module btb_valid_bank #(
   parameter  int unsigned S_INDEX  = 4,
   parameter  int unsigned WAYS     = 2,
   localparam int unsigned W_BITS   = $clog2(WAYS),
   localparam int unsigned NUM_SETS = 2**S_INDEX
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_rd_en,
   input  logic [S_INDEX-1:0] i_rd_addr,
   output logic [WAYS-1:0]    o_rd_valid,
   input  logic               i_wr_en,
   input  logic [S_INDEX-1:0] i_wr_addr,
   input  logic [W_BITS-1:0]  i_wr_way,
   input  logic               i_wr_valid,
   input  logic               i_alloc_en,
   input  logic [S_INDEX-1:0] i_alloc_addr,
   output logic [W_BITS-1:0]  o_alloc_way_c,
   output logic               o_alloc_ack_c,
   input  logic               i_flush_req,
   output logic               o_busy,
   output logic               o_flush_done
);

   typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_busy;
   logic                r_flush_done;
   logic [WAYS-1:0]     r_rd_valid;
   logic [WAYS-1:0]     r_valid [NUM_SETS];
   logic [W_BITS-1:0]   r_ptr   [NUM_SETS];

   logic                w_sweep_last;
   logic                w_last_nxt;
   logic                w_wr_commit;
   logic [WAYS-1:0]     w_alloc_bits;
   logic                w_all_valid;
   logic [W_BITS-1:0]   w_free_way;
   logic [W_BITS-1:0]   w_alloc_way;
   logic                w_alloc_ack;
   logic [WAYS-1:0]     w_rd_bits;

`ifdef BTB_VALID_FLASH_CLEAR_EN
   assign w_sweep_last = 1'b1;
   assign w_last_nxt   = 1'b1;
`else
   localparam logic [S_INDEX-1:0] LAST = S_INDEX'(NUM_SETS - 1);

   logic [S_INDEX-1:0] r_cnt;
   logic [S_INDEX-1:0] w_cnt_nxt;

   // Counter parks at 0 while idle so the sweep always starts from set 0.
   assign w_cnt_nxt    = (r_state == ST_IDLE) ? '0 : r_cnt + S_INDEX'(1);
   assign w_sweep_last = (r_cnt == LAST);
   assign w_last_nxt   = (w_cnt_nxt == LAST);
`endif

   // Flush FSM next state.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (i_flush_req)  w_state_nxt = ST_SWEEP;
         ST_SWEEP: if (w_sweep_last) w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM state, busy and done registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_busy       <= 1'b0;
         r_flush_done <= 1'b0;
`ifndef BTB_VALID_FLASH_CLEAR_EN
         r_cnt        <= '0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_busy       <= (w_state_nxt == ST_SWEEP);
         r_flush_done <= (w_state_nxt == ST_SWEEP) && w_last_nxt;
`ifndef BTB_VALID_FLASH_CLEAR_EN
         r_cnt        <= w_cnt_nxt;
`endif
      end
   end

   // Victim choice: lowest invalid way, else the round-robin pointer.
   assign w_alloc_bits = r_valid[i_alloc_addr];
   assign w_all_valid  = &w_alloc_bits;

   always_comb begin
      w_free_way = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!w_alloc_bits[i]) w_free_way = W_BITS'(i);
      end
   end

   assign w_alloc_way = w_all_valid ? r_ptr[i_alloc_addr] : w_free_way;
   assign w_wr_commit = i_wr_en && !r_busy;
   assign w_alloc_ack = i_alloc_en && !r_busy && !(i_wr_en && (i_wr_addr == i_alloc_addr));

   // Write-first view of the looked-up set.
   always_comb begin
      w_rd_bits = r_valid[i_rd_addr];
      if (w_wr_commit && (i_wr_addr == i_rd_addr)) w_rd_bits[i_wr_way] = i_wr_valid;
      if (w_alloc_ack && (i_alloc_addr == i_rd_addr)) w_rd_bits[w_alloc_way] = 1'b1;
   end

   // Valid bits and victim pointers; the sweep only runs while writes are blocked.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '{default: '0};
         r_ptr   <= '{default: '0};
      end else begin
         if (w_wr_commit) r_valid[i_wr_addr][i_wr_way] <= i_wr_valid;
         if (w_alloc_ack) begin
            r_valid[i_alloc_addr][w_alloc_way] <= 1'b1;
            if (w_all_valid) r_ptr[i_alloc_addr] <= r_ptr[i_alloc_addr] + W_BITS'(1);
         end
         if (r_busy) begin
`ifdef BTB_VALID_FLASH_CLEAR_EN
            r_valid <= '{default: '0};
            r_ptr   <= '{default: '0};
`else
            r_valid[r_cnt] <= '0;
            r_ptr[r_cnt]   <= '0;
`endif
         end
      end
   end

   // Lookup register; a pending flush makes every set read as invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_valid <= '0;
      end else if (i_rd_en) begin
         r_rd_valid <= r_busy ? '0 : w_rd_bits;
      end
   end

   assign o_rd_valid    = r_rd_valid;
   assign o_alloc_way_c = w_alloc_way;
   assign o_alloc_ack_c = w_alloc_ack;
   assign o_busy        = r_busy;
   assign o_flush_done  = r_flush_done;

endmodule

// File: tb/tb_btb_valid_bank.sv
// Bench for btb_valid_bank (S_INDEX=4, WAYS=2): vector table plus flush/reset sequences.
module tb_btb_valid_bank;

`ifdef BTB_VALID_FLASH_CLEAR_EN
   localparam int NSWEEP  = 1;
   localparam int RST_CYC = 1;
`else
   localparam int NSWEEP  = 16;
   localparam int RST_CYC = 5;
`endif

   logic       clk;
   logic       rst;
   logic       i_rd_en;
   logic [3:0] i_rd_addr;
   logic [1:0] o_rd_valid;
   logic       i_wr_en;
   logic [3:0] i_wr_addr;
   logic       i_wr_way;
   logic       i_wr_valid;
   logic       i_alloc_en;
   logic [3:0] i_alloc_addr;
   logic       o_alloc_way_c;
   logic       o_alloc_ack_c;
   logic       i_flush_req;
   logic       o_busy;
   logic       o_flush_done;

   btb_valid_bank #(.S_INDEX(4), .WAYS(2)) dut (
      .clk(clk), .rst(rst),
      .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_valid(o_rd_valid),
      .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_way(i_wr_way), .i_wr_valid(i_wr_valid),
      .i_alloc_en(i_alloc_en), .i_alloc_addr(i_alloc_addr),
      .o_alloc_way_c(o_alloc_way_c), .o_alloc_ack_c(o_alloc_ack_c),
      .i_flush_req(i_flush_req), .o_busy(o_busy), .o_flush_done(o_flush_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rd_en;
      logic [3:0] rd_addr;
      logic [1:0] exp_rd;
      logic       wr_en;
      logic [3:0] wr_addr;
      logic       wr_way;
      logic       wr_valid;
      logic       al_en;
      logic [3:0] al_addr;
      logic       exp_way;
      logic       exp_ack;
   } vec_t;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [1:0] exp_q [$];
   vec_t       vecs  [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rd_en, input logic [3:0] rd_addr, input logic [1:0] exp_rd,
                               input logic wr_en, input logic [3:0] wr_addr, input logic wr_way,
                               input logic wr_valid, input logic al_en, input logic [3:0] al_addr,
                               input logic exp_way, input logic exp_ack);
      vec_t v;
      v.rd_en = rd_en;  v.rd_addr = rd_addr;  v.exp_rd = exp_rd;
      v.wr_en = wr_en;  v.wr_addr = wr_addr;  v.wr_way = wr_way;  v.wr_valid = wr_valid;
      v.al_en = al_en;  v.al_addr = al_addr;  v.exp_way = exp_way; v.exp_ack = exp_ack;
      return v;
   endfunction

   // Advance one clock, then compare any lookup result that was due on this edge.
   task automatic tick();
      logic [1:0] e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("rd_valid", 32'(o_rd_valid), 32'(e));
      end
   endtask

   task automatic idle();
      i_rd_en = 1'b0; i_wr_en = 1'b0; i_alloc_en = 1'b0; i_flush_req = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      i_rd_en    = v.rd_en;  i_rd_addr  = v.rd_addr;
      i_wr_en    = v.wr_en;  i_wr_addr  = v.wr_addr; i_wr_way = v.wr_way; i_wr_valid = v.wr_valid;
      i_alloc_en = v.al_en;  i_alloc_addr = v.al_addr;
      #1;
      if (v.al_en) begin
         chk("alloc_way", 32'(o_alloc_way_c), 32'(v.exp_way));
         chk("alloc_ack", 32'(o_alloc_ack_c), 32'(v.exp_ack));
      end
      if (v.rd_en) exp_q.push_back(v.exp_rd);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      i_rd_addr = '0; i_wr_addr = '0; i_wr_way = 1'b0; i_wr_valid = 1'b0; i_alloc_addr = '0;
      idle();
      tick();
      tick();
      rst = 1'b0;
      chk("reset_rd_valid", 32'(o_rd_valid), 32'd0);
      chk("reset_busy", 32'(o_busy), 32'd0);
      chk("reset_flush_done", 32'(o_flush_done), 32'd0);

      //             rd  ra  erd    wr wa  ww wv   al aa  ew ea
      vecs.push_back(mk(1, 5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 2'b00, 1, 3, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3, 2'b11, 1, 3, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 7, 2'b01, 0, 0, 0, 0, 1, 7, 0, 1));
      vecs.push_back(mk(1, 7, 2'b11, 0, 0, 0, 0, 1, 7, 1, 1));
      vecs.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 7, 0, 1));
      vecs.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 7, 1, 1));
      vecs.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 7, 0, 1));
      vecs.push_back(mk(1, 9, 2'b10, 1, 9, 1, 1, 1, 9, 0, 0));
      vecs.push_back(mk(1, 9, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 10, 2'b01, 1, 9, 0, 1, 1, 10, 0, 1));
      vecs.push_back(mk(1, 9, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3, 2'b01, 1, 3, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3, 2'b11, 0, 0, 0, 0, 1, 3, 1, 1));
      vecs.push_back(mk(1, 7, 2'b01, 1, 7, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 7, 2'b11, 0, 0, 0, 0, 1, 7, 1, 1));
      vecs.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 7, 1, 1));
      vecs.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 7, 0, 1));
      foreach (vecs[k]) apply(vecs[k]);
      idle();

      // Fill way 0 everywhere; set 12 then holds 01, and rd_valid must hold without rd_en.
      for (int s = 0; s < 16; s++) apply(mk(0, 0, 2'b00, 1, 4'(s), 0, 1, 0, 0, 0, 0));
      apply(mk(1, 12, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
      apply(mk(0, 0, 2'b00, 1, 12, 1, 1, 0, 0, 0, 0));
      chk("rd_hold", 32'(o_rd_valid), 32'(2'b01));

      // Flush sweep: writes dropped and lookups read zero while busy.
      idle();
      i_flush_req = 1'b1;
      tick();
      i_flush_req = 1'b0;
      for (int c = 1; c <= NSWEEP; c++) begin
         chk("sweep_busy", 32'(o_busy), 32'd1);
         chk("sweep_done", 32'(o_flush_done), 32'(c == NSWEEP));
         i_rd_en = 1'b1; i_rd_addr = 4'(c + 11);
         exp_q.push_back(2'b00);
         i_wr_en = (c == 4); i_wr_addr = 4'd0; i_wr_way = 1'b1; i_wr_valid = 1'b1;
         tick();
      end
      idle();
      chk("post_sweep_busy", 32'(o_busy), 32'd0);
      chk("post_sweep_done", 32'(o_flush_done), 32'd0);
      for (int s = 0; s < 16; s++) apply(mk(1, 4'(s), 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

      // Reset in the middle of a sweep; set 7 pointer is first moved to 1.
      apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 7, 0, 1));
      apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 7, 1, 1));
      apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 7, 0, 1));
      for (int s = 0; s < 16; s++) apply(mk(0, 0, 2'b00, 1, 4'(s), 1, 1, 0, 0, 0, 0));
      apply(mk(1, 14, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
      idle();
      i_flush_req = 1'b1;
      tick();
      i_flush_req = 1'b0;
      for (int c = 1; c < RST_CYC; c++) begin
         chk("pre_rst_busy", 32'(o_busy), 32'd1);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_flush_done), 32'd0);
      chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
      for (int c = 0; c < 20; c++) begin
         chk("rst_no_done", 32'(o_flush_done), 32'd0);
         chk("rst_idle", 32'(o_busy), 32'd0);
         tick();
      end
      for (int s = 0; s < 16; s++) apply(mk(1, 4'(s), 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 7, 0, 1));
      apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 7, 1, 1));
      apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 7, 0, 1));
      apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 7, 1, 1));
      idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
